// File: rtl/acc_bank.sv
// Bank of NACC accumulators with a shared save stack for context save/restore.
// One accumulator, picked by sel, is updated per cycle under a 3-bit opcode.
module acc_bank #(
  parameter int DW    = 8,
  parameter int NACC  = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NACC)-1:0] sel,
  input  logic [2:0]              op,
  input  logic [DW-1:0]           alu_in,
  input  logic [DW-1:0]           file_in,
  input  logic                    err_clr,
  output logic [DW-1:0]           acc,
  output logic                    zero,
  output logic                    neg,
  output logic                    carry,
  output logic                    stk_full,
  output logic                    stk_empty,
  output logic                    err
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD    = 3'b000,
    OP_LD_ALU  = 3'b001,
    OP_LD_FILE = 3'b010,
    OP_SHL     = 3'b011,
    OP_SHR     = 3'b100,
    OP_CLR     = 3'b101,
    OP_PUSH    = 3'b110,
    OP_POP     = 3'b111
  } op_e;

  op_e           op_s;
  logic [DW-1:0] acc_q [NACC];
  logic [DW-1:0] stack_q [2**AW];
  logic [PW-1:0] sp_q, sp_d, sp_m1;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          push_en;
  logic          full, empty;

  assign op_s  = op_e'(op);
  assign full  = (sp_q == PW'(DEPTH));
  assign empty = (sp_q == '0);
  assign sp_m1 = sp_q - PW'(1);

  assign acc       = acc_q[sel];
  assign zero      = (acc == '0);
  assign neg       = acc[DW-1];
  assign carry     = carry_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign err       = err_q;

  always_comb begin
    // NOTE: every signal gets a default up front so no path through the case infers a latch.
    wr_en   = 1'b0;
    wr_data = acc;
    push_en = 1'b0;
    sp_d    = sp_q;
    carry_d = carry_q;
    err_d   = err_clr ? 1'b0 : err_q;
    unique case (op_s)
      OP_HOLD:    ;
      OP_LD_ALU:  begin wr_en = 1'b1; wr_data = alu_in;  end
      OP_LD_FILE: begin wr_en = 1'b1; wr_data = file_in; end
      OP_SHL: begin
        wr_en   = 1'b1;
        wr_data = {acc[DW-2:0], 1'b0};
        carry_d = acc[DW-1];
      end
      OP_SHR: begin
        wr_en   = 1'b1;
        wr_data = {1'b0, acc[DW-1:1]};
        carry_d = acc[0];
      end
      OP_CLR: begin
        wr_en   = 1'b1;
        wr_data = '0;
        carry_d = 1'b0;
      end
      OP_PUSH: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + PW'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_data = stack_q[sp_m1[AW-1:0]];
          sp_d    = sp_m1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
      sp_q    <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      if (wr_en) acc_q[sel] <= wr_data;
      sp_q    <= sp_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the stack storage has no reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q[AW-1:0]] <= acc;
  end

endmodule
